// File: rtl/svc_soc_io_uart_rx.sv
// Memory-mapped 8N1 UART receiver: 2-flop synchronizer, bit-timing FSM, byte FIFO,
// and RX_DATA (pop) / RX_STATUS (W1C error flags) registers on the SoC I/O bus.
module svc_soc_io_uart_rx #(
    parameter int unsigned CLOCK_FREQ = 25_000_000,
    parameter int unsigned BAUD_RATE  = 115_200,
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0010,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        uart_rx,
    input  logic        io_ren,
    input  logic [31:0] io_raddr,
    output logic [31:0] io_rdata,
    input  logic        io_wen,
    input  logic [31:0] io_waddr,
    input  logic [31:0] io_wdata,
    input  logic [3:0]  io_wstrb,
    output logic        rx_not_empty
);

    localparam int unsigned CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
    localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int unsigned AW           = $clog2(FIFO_DEPTH);
    localparam logic [31:0] STATUS_ADDR  = BASE_ADDR + 32'd4;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [AW:0]      PTR_ONE  = (AW+1)'(1);
    localparam logic [AW:0]      PTR_FULL = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_STOP, S_BREAK
    } state_t;

    state_t          state, state_nxt;
    logic            rx_meta, rx_s;
    logic [CNT_W-1:0] clk_cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shreg;

    logic cnt_last, cnt_half;
    logic cnt_run, cnt_clr, shift_en, push_req, frame_set;

    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt, count, count_nxt;
    logic        empty, full, push, pop, ovr_set;
    logic        frame_err, overrun;
    logic        rd_data_hit, rd_stat_hit, wr_stat, clr_ferr, clr_ovr;
    logic [7:0]  count8;
    logic [31:0] status_word, rdata_nxt;

    logic unused_bits;
    assign unused_bits = ^{io_wdata[31:3], io_wdata[0], io_wstrb[3:1]};

    // Synchronizer resets to the idle (mark) level so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_s    <= rx_meta;
        end
    end

    assign cnt_last = (clk_cnt == CNT_LAST);
    assign cnt_half = (clk_cnt == CNT_HALF);

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (!rx_s) state_nxt = S_START;
            S_START: if (cnt_half) state_nxt = rx_s ? S_IDLE : S_DATA;
            S_DATA:  if (cnt_last && bit_idx == 3'd7) state_nxt = S_STOP;
            S_STOP:  if (cnt_last) state_nxt = rx_s ? S_IDLE : S_BREAK;
            S_BREAK: if (rx_s) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_run   = (state == S_START) || (state == S_DATA) || (state == S_STOP);
        shift_en  = (state == S_DATA) && cnt_last;
        push_req  = (state == S_STOP) && cnt_last && rx_s;
        frame_set = (state == S_STOP) && cnt_last && !rx_s;
        cnt_clr   = (state_nxt != state) || shift_en;
    end

    // Datapath; the partial byte is simply abandoned on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_cnt <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            clk_cnt <= (cnt_clr || !cnt_run) ? '0 : clk_cnt + CNT_ONE;
            if (state == S_START) bit_idx <= '0;
            else if (shift_en)    bit_idx <= bit_idx + 3'd1;
            if (shift_en) shreg <= {rx_s, shreg[7:1]};
        end
    end

    assign count = wr_ptr - rd_ptr;
    assign empty = (count == '0);
    assign full  = (count == PTR_FULL);

    assign rd_data_hit = io_ren && (io_raddr == BASE_ADDR);
    assign rd_stat_hit = io_ren && (io_raddr == STATUS_ADDR);
    assign wr_stat     = io_wen && (io_waddr == STATUS_ADDR) && io_wstrb[0];
    assign clr_ferr    = wr_stat && io_wdata[1];
    assign clr_ovr     = wr_stat && io_wdata[2];

    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign pop     = rd_data_hit && !empty;
    assign push    = push_req && (!full || pop);
    assign ovr_set = push_req && full && !pop;

    assign wr_ptr_nxt = push ? wr_ptr + PTR_ONE : wr_ptr;
    assign rd_ptr_nxt = pop  ? rd_ptr + PTR_ONE : rd_ptr;
    assign count_nxt  = wr_ptr_nxt - rd_ptr_nxt;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= shreg;
    end

    assign count8      = 8'(count);
    assign status_word = {16'h0, count8, 5'b0, overrun, frame_err, !empty};

    always_comb begin
        rdata_nxt = '0;
        if (rd_data_hit) begin
            if (!empty) rdata_nxt = {23'b0, 1'b1, mem[rd_ptr[AW-1:0]]};
        end else if (rd_stat_hit) begin
            rdata_nxt = status_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            rx_not_empty <= 1'b0;
            frame_err    <= 1'b0;
            overrun      <= 1'b0;
            io_rdata     <= '0;
        end else begin
            wr_ptr       <= wr_ptr_nxt;
            rd_ptr       <= rd_ptr_nxt;
            rx_not_empty <= (count_nxt != '0);
            io_rdata     <= rdata_nxt;
            if (frame_set)     frame_err <= 1'b1;
            else if (clr_ferr) frame_err <= 1'b0;
            if (ovr_set)       overrun <= 1'b1;
            else if (clr_ovr)  overrun <= 1'b0;
        end
    end

endmodule
